// File: rtl/wdog_led_feedback_if.sv
// wdog_led_feedback_if: status inputs and LED outputs of the watchdog LED driver
//   wdog_period_status : watchdog period phase (0 = disabled, 1..5 = phase)
//   wdog_timeout_led   : latched watchdog timeout, level-sensitive
//   led_out            : LED drive, 1 = lit
//   led_state          : FSM state for debug (IDLE=0, ON=1, OFF=2, GAP=3, FAULT=4)
//   blink_idx          : blink number within the sequence, 0 in IDLE and FAULT
interface wdog_led_feedback_if;
    logic [2:0] wdog_period_status;
    logic       wdog_timeout_led;
    logic       led_out;
    logic [2:0] led_state;
    logic [2:0] blink_idx;
    modport master (
        output wdog_period_status, wdog_timeout_led,
        input  led_out, led_state, blink_idx
    );
    modport slave (
        input  wdog_period_status, wdog_timeout_led,
        output led_out, led_state, blink_idx
    );
endinterface

// File: rtl/wdog_led_feedback.sv
// wdog_led_feedback: blinks the watchdog LED once per period phase, fast-flashes on timeout
//   sysclk : system clock
//   reset  : asynchronous active-high reset
//   bus    : status inputs and LED/debug outputs (slave side of wdog_led_feedback_if)
module wdog_led_feedback #(
    parameter int CLK_DIV    = 49152,
    parameter int ON_TICKS   = 200,
    parameter int OFF_TICKS  = 200,
    parameter int GAP_TICKS  = 1000,
    parameter int FAST_TICKS = 100
) (
    input logic                sysclk,
    input logic                reset,
    wdog_led_feedback_if.slave bus
);
    typedef enum logic [2:0] {IDLE = 3'd0, ON = 3'd1, OFF = 3'd2, GAP = 3'd3, FAULT = 3'd4} state_t;
    localparam int MAX_A = ON_TICKS > OFF_TICKS ? ON_TICKS : OFF_TICKS;
    localparam int MAX_B = GAP_TICKS > FAST_TICKS ? GAP_TICKS : FAST_TICKS;
    localparam int MAXT  = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int PW    = $clog2(CLK_DIV) > 0 ? $clog2(CLK_DIV) : 1;
    localparam int TW    = $clog2(MAXT) > 0 ? $clog2(MAXT) : 1;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tmr_q, tmr_d, tmr_lim;
    state_t        state_q, state_d;
    logic          led_q, led_d;
    logic [2:0]    blink_q, blink_d, n_q, n_d;
    logic          tick, tmr_last, status_ok;
    assign tick      = presc_q == PW'(CLK_DIV - 1);
    assign status_ok = bus.wdog_period_status >= 3'd1 && bus.wdog_period_status <= 3'd5;
    assign tmr_lim   = state_q == ON  ? TW'(ON_TICKS - 1)  :
                       state_q == OFF ? TW'(OFF_TICKS - 1) :
                       state_q == GAP ? TW'(GAP_TICKS - 1) : TW'(FAST_TICKS - 1);
    assign tmr_last  = tmr_q == tmr_lim;
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        state_d = state_q;
        led_d   = led_q;
        blink_d = blink_q;
        n_d     = n_q;
        tmr_d   = tmr_q;
        // timeout entry and exit are checked every cycle and beat any tick-driven move
        if (state_q != FAULT && bus.wdog_timeout_led) begin
            state_d = FAULT;
            led_d   = 1'b1;
            blink_d = '0;
            tmr_d   = '0;
        end else if (state_q == FAULT) begin
            if (!bus.wdog_timeout_led) begin
                state_d = IDLE;
                led_d   = 1'b0;
                blink_d = '0;
                tmr_d   = '0;
            end else if (tick) begin
                tmr_d = tmr_last ? '0 : tmr_q + 1'b1;
                led_d = led_q ^ tmr_last;
            end
        end else if (tick) begin
            // every tick-driven transition happens on tmr_last, so this also clears tmr on entry
            tmr_d = (tmr_last || state_q == IDLE) ? '0 : tmr_q + 1'b1;
            case (state_q)
                IDLE: if (status_ok) begin
                    state_d = ON;
                    n_d     = bus.wdog_period_status;
                    blink_d = 3'd1;
                    led_d   = 1'b1;
                end
                ON: if (tmr_last) begin
                    state_d = OFF;
                    led_d   = 1'b0;
                end
                OFF: if (tmr_last) begin
                    if (blink_q < n_q) begin
                        blink_d = blink_q + 3'd1;
                        state_d = ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end
                GAP: if (tmr_last) begin
                    state_d = IDLE;
                    blink_d = '0;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tmr_q   <= '0;
            state_q <= IDLE;
            led_q   <= 1'b0;
            blink_q <= '0;
            n_q     <= '0;
        end else begin
            presc_q <= presc_d;
            tmr_q   <= tmr_d;
            state_q <= state_d;
            led_q   <= led_d;
            blink_q <= blink_d;
            n_q     <= n_d;
        end
    end
    assign bus.led_out   = led_q;
    assign bus.led_state = state_q;
    assign bus.blink_idx = blink_q;
endmodule

// File: tb/tb_wdog_led_feedback.sv
// tb_wdog_led_feedback: sequence-arithmetic reference model plus directed scenarios
module tb_wdog_led_feedback;
    localparam int CD = 4, ONT = 2, OFFT = 2, GT = 5, FT = 3, P = ONT + OFFT;
    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    wdog_led_feedback_if bus();
    wdog_led_feedback #(
        .CLK_DIV(CD), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GT), .FAST_TICKS(FT)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 sysclk = ~sysclk;
    int tests = 0, fails = 0;
    // model: mode 0 idle, 1 in a sequence (k = ticks since start), 2 timeout flash (ft = ticks since entry)
    int m_mode = 0, m_k = 0, m_n = 0, m_ft = 0, m_e = 0;
    int cyc = 0, rises = 0, maxb = 0;
    logic prev_led = 1'b0;
    int rise_t[$], fall_t[$], chg_t[$];
    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_k <= 0; m_n <= 0; m_ft <= 0; m_e <= 0;
        end else begin
            m_e <= m_e + 1;
            if (m_mode != 2 && bus.wdog_timeout_led) begin
                m_mode <= 2; m_ft <= 0;
            end else if (m_mode == 2) begin
                if (!bus.wdog_timeout_led) m_mode <= 0;
                else if (m_e % CD == CD - 1) m_ft <= m_ft + 1;
            end else if (m_e % CD == CD - 1) begin
                if (m_mode == 0) begin
                    if (bus.wdog_period_status >= 1 && bus.wdog_period_status <= 5) begin
                        m_mode <= 1; m_n <= int'(bus.wdog_period_status); m_k <= 0;
                    end
                end else if (m_k + 1 == m_n * P + GT) m_mode <= 0;
                else m_k <= m_k + 1;
            end
        end
    end
    always @(negedge sysclk) begin
        int e_led, e_st, e_bl;
        if (!reset) begin
            e_led = 0; e_st = 0; e_bl = 0;
            if (m_mode == 2) begin
                e_led = ((m_ft / FT) % 2 == 0) ? 1 : 0; e_st = 4;
            end else if (m_mode == 1) begin
                if (m_k < m_n * P) begin
                    e_led = (m_k % P < ONT) ? 1 : 0;
                    e_st  = (m_k % P < ONT) ? 1 : 2;
                    e_bl  = m_k / P + 1;
                end else begin
                    e_st = 3; e_bl = m_n;
                end
            end
            chk("model_led", int'(bus.led_out), e_led);
            chk("model_state", int'(bus.led_state), e_st);
            chk("model_blink", int'(bus.blink_idx), e_bl);
        end
    end
    task automatic step();
        @(negedge sysclk);
        cyc++;
        if (!prev_led && bus.led_out) begin rises++; rise_t.push_back(cyc); end
        if (prev_led && !bus.led_out) fall_t.push_back(cyc);
        if (prev_led != bus.led_out) chg_t.push_back(cyc);
        if (int'(bus.blink_idx) > maxb) maxb = int'(bus.blink_idx);
        prev_led = bus.led_out;
    endtask
    task automatic clear();
        rises = 0; maxb = 0;
        rise_t.delete(); fall_t.delete(); chg_t.delete();
    endtask
    task automatic wait_led(input logic v, input int bound, input string nm);
        for (int i = 0; i < bound && bus.led_out !== v; i++) step();
        chk(nm, int'(bus.led_out), int'(v));
    endtask
    task automatic wait_state(input int s, input int bound, input string nm);
        for (int i = 0; i < bound && int'(bus.led_state) != s; i++) step();
        chk(nm, int'(bus.led_state), s);
    endtask
    initial begin
        int k;
        bus.wdog_period_status = 3'd0;
        bus.wdog_timeout_led   = 1'b0;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        chk("rst_led", int'(bus.led_out), 0);
        chk("rst_state", int'(bus.led_state), 0);
        chk("rst_blink", int'(bus.blink_idx), 0);
        clear();
        repeat (200) step();
        chk("idle0_rises", rises, 0);
        clear();
        bus.wdog_period_status = 3'd2;
        wait_led(1'b1, 20, "s2_start");
        for (int i = 0; i < 200 && rise_t.size() < 3; i++) step();
        chk("s2_three_rises", int'(rise_t.size() >= 3), 1);
        if (rise_t.size() >= 3 && fall_t.size() >= 2) begin
            chk("s2_on1", fall_t[0] - rise_t[0], 8);
            chk("s2_off1", rise_t[1] - fall_t[0], 8);
            chk("s2_on2", fall_t[1] - rise_t[1], 8);
            chk("s2_dark", rise_t[2] - fall_t[1], 32);
            chk("s2_period", rise_t[2] - rise_t[0], 56);
        end
        chk("s2_maxblink", maxb, 2);
        bus.wdog_period_status = 3'd0;
        wait_state(0, 200, "s3_idle");
        clear();
        bus.wdog_period_status = 3'd2;
        wait_led(1'b1, 20, "s3_start1");
        bus.wdog_period_status = 3'd5;
        wait_state(0, 200, "s3_end1");
        chk("s3_blinks1", rises, 2);
        chk("s3_maxblink1", maxb, 2);
        clear();
        wait_led(1'b1, 20, "s3_start2");
        wait_state(0, 400, "s3_end2");
        chk("s3_blinks2", rises, 5);
        chk("s3_maxblink2", maxb, 5);
        wait_state(3, 400, "s4_gap");
        bus.wdog_timeout_led = 1'b1;
        step();
        chk("s4_led", int'(bus.led_out), 1);
        chk("s4_state", int'(bus.led_state), 4);
        chk("s4_blink", int'(bus.blink_idx), 0);
        clear();
        for (int i = 0; i < 60 && chg_t.size() < 3; i++) step();
        chk("s4_toggles", int'(chg_t.size() >= 3), 1);
        if (chg_t.size() >= 3) begin
            chk("s4_half1", chg_t[1] - chg_t[0], 12);
            chk("s4_half2", chg_t[2] - chg_t[1], 12);
        end
        bus.wdog_timeout_led = 1'b0;
        step();
        chk("s5_led", int'(bus.led_out), 0);
        chk("s5_state", int'(bus.led_state), 0);
        chk("s5_blink", int'(bus.blink_idx), 0);
        clear();
        wait_state(1, CD, "s5_restart");
        repeat (10) step();
        bus.wdog_period_status = 3'd0;
        wait_state(0, 200, "s6_end");
        chk("s6_blinks", rises, 5);
        clear();
        repeat (200) step();
        chk("s6_dark", rises, 0);
        bus.wdog_period_status = 3'd7;
        clear();
        repeat (200) step();
        chk("s7_rises", rises, 0);
        chk("s7_state", int'(bus.led_state), 0);
        bus.wdog_period_status = 3'd2;
        wait_led(1'b1, 20, "ar_on");
        step();
        #2 reset = 1'b1;
        #1;
        chk("ar_led", int'(bus.led_out), 0);
        chk("ar_state", int'(bus.led_state), 0);
        chk("ar_blink", int'(bus.blink_idx), 0);
        @(negedge sysclk);
        reset = 1'b0;
        prev_led = 1'b0;
        clear();
        k = 0;
        while (bus.led_out !== 1'b1 && k < 20) begin step(); k++; end
        chk("ar_first_tick", k, 4);
        repeat (20) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wdog_led_feedback.md
# wdog_led_feedback

Drives the board's watchdog status LED from the watchdog-period classification and timeout flag produced by the board register file. In normal operation it blinks the LED N times, where N is the watchdog period phase (1–5), then holds a dark gap and repeats. A latched watchdog timeout overrides this with a fast continuous flash. The block sits between the board register file outputs (`wdog_period_status`, `wdog_timeout_led`) and the LED pin in the top level.

## Interface

Parameters:
- `CLK_DIV`, default 49152: sysclk cycles per tick (1 ms at 49.152 MHz).
- `ON_TICKS`, default 200: LED-on duration of one blink.
- `OFF_TICKS`, default 200: LED-off duration between blinks.
- `GAP_TICKS`, default 1000: dark gap after the last blink of a sequence.
- `FAST_TICKS`, default 100: half-period of the timeout flash.

Ports:
- `sysclk`, input, 1: system clock. This is the only clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `wdog_period_status`, input, 3: period phase. Encoding per Constants.v: 0 = `WDOG_DISABLE`, 1–5 = `WDOG_PHASE_ONE`..`WDOG_PHASE_FIVE`. Codes 6 and 7 are treated as disabled.
- `wdog_timeout_led`, input, 1: latched watchdog timeout, level-sensitive.
- `led_out`, output, 1: LED drive, 1 = lit.
- `led_state`, output, 3: FSM state for debug (IDLE=0, ON=1, OFF=2, GAP=3, FAULT=4).
- `blink_idx`, output, 3: current blink number within the sequence, 1..n; 0 in IDLE and FAULT.

## Operation

- The prescaler counts 0..`CLK_DIV`-1 and wraps. `tick` is a one-cycle pulse when the count equals `CLK_DIV`-1.
- The prescaler is free-running; only reset clears it.
- The tick timer `tmr` is sized for the maximum of the TICKS parameters. It is cleared on every state entry.
- Inputs are sampled directly; they are sysclk-domain register outputs.

FSM transitions. Each state condition is checked on `tick` only, except where noted.
- **IDLE**, `led_out`=0. If status is in 1..5:
  - latch `n`=status, set `blink_idx`=1, `led_out`=1, go to ON.
  - Otherwise (status 0, 6 or 7) stay in IDLE.
- **ON**, `led_out`=1. When `tmr`==`ON_TICKS`-1: go to OFF, `led_out`=0. Otherwise `tmr`++.
- **OFF**, `led_out`=0. When `tmr`==`OFF_TICKS`-1:
  - if `blink_idx`<`n`: `blink_idx`++, go to ON, `led_out`=1;
  - else go to GAP.
- **GAP**, `led_out`=0. When `tmr`==`GAP_TICKS`-1, go to IDLE. IDLE then acts on the following tick.
- **FAULT**:
  - On the sysclk edge after `wdog_timeout_led`=1 is seen in any other state, enter FAULT with `led_out`=1, `tmr`=0. Entry is not tick-gated.
  - Each time `tmr`==`FAST_TICKS`-1 on a tick: toggle `led_out`, `tmr`=0.
  - When `wdog_timeout_led`=0 (checked every sysclk), go to IDLE with `led_out`=0 and `blink_idx`=0.

Rules:
- `n` is latched only in IDLE. Status changes mid-sequence take effect at the next sequence.
- A status change to 0 mid-sequence finishes the current sequence, then the block holds dark.
- A timeout takes priority over all tick-driven transitions in the same cycle.

## Timing

- Reset values: `led_out`=0, `led_state`=IDLE, `blink_idx`=0, prescaler=0, `tmr`=0, `n`=0.
- Reset asserted mid-sequence forces these values immediately (asynchronous). The first tick after release occurs `CLK_DIV` cycles after the first active edge.
- All outputs are registered. `led_out` changes on the sysclk edge that samples `tick`.
- Sequence length for phase n, in ticks: n·(`ON_TICKS`+`OFF_TICKS`) + `GAP_TICKS` + 1 (the extra tick is IDLE). At defaults, phase 3 gives 2201 ms.
- Timeout latency: `led_out`=1 one sysclk after `wdog_timeout_led` rises.
- Recovery latency: `led_out`=0 one sysclk after `wdog_timeout_led` falls. The next sequence starts on the following tick.

## Test plan

Bench parameters for all scenarios: `CLK_DIV`=4, `ON_TICKS`=2, `OFF_TICKS`=2, `GAP_TICKS`=5, `FAST_TICKS`=3.

- **Reset, then hold status=0:**
  - Required: `led_out`=0 and `led_state`=0 for 200 cycles.
  - Asserting `reset` asynchronously mid-cycle clears all outputs without waiting for a clock edge.
- **Status=2:**
  - Required: `led_out` shows high 8 cycles, low 8, high 8, low 8, then low 24 (GAP + IDLE).
  - Repeat period is 56 cycles; `blink_idx` steps 1,2.
- **Status 2→5 during the first blink:**
  - Required: the current sequence completes with 2 blinks.
  - The next sequence has 5 blinks; `blink_idx` reaches 5.
- **`wdog_timeout_led` 0→1 while in GAP:**
  - Required: `led_out`=1 the next cycle, `led_state`=4.
  - `led_out` then toggles every 12 cycles.
- **`wdog_timeout_led` 1→0:**
  - Required: `led_out`=0 and IDLE the next cycle.
  - A new blink sequence starts at the next tick.
- **Status 7 and status 0:**
  - Required: no blinks while in IDLE.
  - A change to 0 mid-sequence completes the current sequence, then the LED stays dark.
